// File: rtl/shift_right_seq_if.sv
// Request/result bundle for the sequential right shifter.
// The master drives the request and operands and the slave returns the
// result together with its busy/done status.
interface shift_right_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [4:0]       B;
    logic             S;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, S,
        input  R, busy, done
    );

    modport slave (
        input  start, A, B, S,
        output R, busy, done
    );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential right shifter with a selectable fill bit.
// Each clock shifts the operand right by one position and inserts the fill
// bit at the MSB. An operation of amount B completes B+1 edges after it is
// accepted. Only the final value is copied to R, so intermediate values are
// never visible on the result port.
module shift_right_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    shift_right_seq_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [4:0]       cnt_q;
    logic [4:0]       cnt_d;
    logic             fill_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             done_q;

    // One shift step and a count decrement that saturates at zero.
    always_comb begin
        work_d = {fill_q, work_q[WIDTH-1:1]};
        if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
        end else begin
            cnt_d = 5'd0;
        end
    end

    // Control FSM with registered result, busy and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= 5'd0;
            fill_q  <= 1'b0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        work_q  <= bus.A;
                        cnt_q   <= bus.B;
                        fill_q  <= bus.S;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt_q != 5'd0) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_d;
                    end else begin
                        // Completion edge: a start seen here is deliberately dropped.
                        r_q     <= work_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.R    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and random checks for the sequential right shifter.
module tb_shift_right_seq;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_right_seq_if #(.WIDTH(32)) bus ();

    shift_right_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from IDLE, scrambles the operands after the
    // accepting edge and waits (bounded) for done. Performs no comparisons.
    task automatic do_op(input logic [31:0] a, input logic [4:0] b, input logic s,
                         output logic [31:0] r, output int lat, output int busy_cnt,
                         output bit got_done);
        bus.A     = a;
        bus.B     = b;
        bus.S     = s;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.S     = ~s;
        busy_cnt  = bus.busy ? 1 : 0;
        lat       = 0;
        got_done  = 1'b0;
        r         = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (!got_done) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (bus.done) begin
                    got_done = 1'b1;
                    r        = bus.R;
                end else if (bus.busy) begin
                    busy_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.A     = 32'hDEADBEEF;
        bus.B     = 5'd3;
        bus.S     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.R !== 32'h0) begin
            errors++; $display("FAIL reset_R actual=%h expected=%h", bus.R, 32'h0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy actual=%b expected=0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done actual=%b expected=0", bus.done);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_start_discarded busy actual=%b expected=0", bus.busy);
        end
    endtask

    task automatic test_logical();
        logic [31:0] r;
        int lat, bc;
        bit ok;
        do_op(32'h80000000, 5'd4, 1'b0, r, lat, bc, ok);
        checks++;
        if (!ok || r !== 32'h08000000) begin
            errors++; $display("FAIL logical_R actual=%h done=%b expected=%h", r, ok, 32'h08000000);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL logical_latency actual=%0d expected=5", lat);
        end
        checks++;
        if (bc !== 5) begin
            errors++; $display("FAIL logical_busy_cycles actual=%0d expected=5", bc);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.R !== 32'h08000000) begin
            errors++; $display("FAIL logical_done_pulse done=%b R=%h expected done=0 R=%h", bus.done, bus.R, 32'h08000000);
        end
    endtask

    task automatic test_arith_and_zero();
        logic [31:0] r;
        int lat, bc;
        bit ok;
        do_op(32'hF0000000, 5'd31, 1'b1, r, lat, bc, ok);
        checks++;
        if (!ok || r !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL arith_R actual=%h expected=%h", r, 32'hFFFFFFFF);
        end
        checks++;
        if (lat !== 32) begin
            errors++; $display("FAIL arith_latency actual=%0d expected=32", lat);
        end
        do_op(32'h12345678, 5'd0, 1'b0, r, lat, bc, ok);
        checks++;
        if (!ok || r !== 32'h12345678) begin
            errors++; $display("FAIL zero_R actual=%h expected=%h", r, 32'h12345678);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL zero_latency actual=%0d expected=1", lat);
        end
    endtask

    task automatic test_ignore_busy();
        int dones;
        int done_edge;
        logic [31:0] r;
        bus.A     = 32'hFFFF0000;
        bus.B     = 5'd8;
        bus.S     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dones     = 0;
        done_edge = -1;
        r         = 32'h0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) begin
                bus.start = 1'b1;
                bus.A     = 32'h1;
                bus.B     = 5'd1;
            end
            @(posedge clk);
            @(negedge clk);
            if (e == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                done_edge = e;
                r = bus.R;
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL ignore_busy_done_count actual=%0d expected=1", dones);
        end
        checks++;
        if (r !== 32'h00FFFF00) begin
            errors++; $display("FAIL ignore_busy_R actual=%h expected=%h", r, 32'h00FFFF00);
        end
        checks++;
        if (done_edge !== 9) begin
            errors++; $display("FAIL ignore_busy_latency actual=%0d expected=9", done_edge);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [31:0] r;
        int lat, bc;
        bit ok;
        bus.A     = 32'hAAAAAAAA;
        bus.B     = 5'd20;
        bus.S     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.R !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state R=%h busy=%b done=%b expected 0/0/0", bus.R, bus.busy, bus.done);
        end
        dones = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL reset_mid_no_done actual=%0d expected=0", dones);
        end
        do_op(32'h00000100, 5'd8, 1'b0, r, lat, bc, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            errors++; $display("FAIL reset_mid_recover_R actual=%h expected=%h", r, 32'h1);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int edge1, edge2;
        logic [31:0] r1, r2;
        bus.A     = 32'h80;
        bus.B     = 5'd3;
        bus.S     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.B = 5'd7;
        dones = 0;
        edge1 = -1; edge2 = -1;
        r1 = 32'h0; r2 = 32'h0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 5) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++; $display("FAIL b2b_second_accept busy actual=%b expected=1", bus.busy);
                end
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                if (dones == 1) begin edge1 = e; r1 = bus.R; end
                else begin edge2 = e; r2 = bus.R; end
            end
        end
        checks++;
        if (dones !== 2) begin
            errors++; $display("FAIL b2b_done_count actual=%0d expected=2", dones);
        end
        checks++;
        if (edge1 !== 4 || r1 !== 32'h10) begin
            errors++; $display("FAIL b2b_first edge=%0d R=%h expected edge=4 R=%h", edge1, r1, 32'h10);
        end
        checks++;
        if (edge2 !== 13 || r2 !== 32'h1) begin
            errors++; $display("FAIL b2b_second edge=%0d R=%h expected edge=13 R=%h", edge2, r2, 32'h1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, r, expv;
        logic [4:0]  b;
        logic        s;
        int lat, bc;
        bit ok;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = 5'($urandom_range(0, 31));
            s = 1'($urandom_range(0, 1));
            expv = (a >> b) | (s ? ~(32'hFFFFFFFF >> b) : 32'h0);
            do_op(a, b, s, r, lat, bc, ok);
            checks++;
            if (!ok || r !== expv) begin
                errors++; $display("FAIL random_R A=%h B=%0d S=%b actual=%h expected=%h", a, b, s, r, expv);
            end
            checks++;
            if (lat !== int'(b) + 1) begin
                errors++; $display("FAIL random_latency B=%0d actual=%0d expected=%0d", b, lat, int'(b) + 1);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 32'h0;
        bus.B     = 5'd0;
        bus.S     = 1'b0;
        test_reset();
        test_logical();
        test_arith_and_zero();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
